// File: rtl/uart_pkg.sv
// Shared UART types and helpers: receiver FSM states, default timing, width helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_SB_TICK    = 16;

  // Counter width for values 0..v-1, never narrower than one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; 2 clk latency, no backpressure.
// RST_VAL sets the reset level so idle-high lines do not fake an edge on reset release.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver, DBIT data bits, optional parity via UART_RX_PARITY_EN.
// rx_done_tick one clk after the last stop-interval tick; no backpressure, dout valid until the next frame.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int SB_TICK    = DEF_SB_TICK,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            rx,
  input  logic            s_tick,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout,
  output logic            frame_err,
  output logic            parity_err
);

  localparam int SW = clog2((OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK);
  localparam int NW = clog2(DBIT);

  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  state_t          state;
  logic [SW-1:0]   s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] b;
  logic            rx_s;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_rx_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (rx),
    .q      (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic p;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      p            <= 1'b0;
      parity_err   <= 1'b0;
`endif
    end else begin
      rx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s     <= '0;
          end
        end
        START: begin
          if (s_tick) begin
            // A start bit that is high again at its midpoint was a glitch.
            if (s == S_MID) begin
              if (!rx_s) begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s == S_BIT) begin
              s <= '0;
              b <= {rx_s, b[DBIT-1:1]};
              if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                n <= n + 1'b1;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (s_tick) begin
            if (s == S_BIT) begin
              p     <= rx_s;
              s     <= '0;
              state <= STOP;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (s_tick) begin
            if (s == S_STOP) begin
              state        <= IDLE;
              rx_done_tick <= 1'b1;
              dout         <= b;
              frame_err    <= ~rx_s;
`ifdef UART_RX_PARITY_EN
              parity_err   <= ^b ^ p ^ 1'(PARITY_ODD);
`endif
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Randomized bench for uart_rx_param: two configurations driven by a tick-level line model.
module tb_uart_rx_param;

  localparam int OS   = 16;
  localparam int DB_A = 8;
  localparam int SB_A = 16;
  localparam int DB_B = 7;
  localparam int SB_B = 32;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic            clk;
  logic            reset_n;
  logic            s_tick;
  logic            rx_a, rx_b;
  logic            done_a, done_b;
  logic [DB_A-1:0] dout_a;
  logic [DB_B-1:0] dout_b;
  logic            ferr_a, ferr_b, perr_a, perr_b;

  uart_rx_param #(
    .DBIT(DB_A), .OVERSAMPLE(OS), .SB_TICK(SB_A), .PARITY_ODD(0)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .rx(rx_a), .s_tick(s_tick),
    .rx_done_tick(done_a), .dout(dout_a), .frame_err(ferr_a), .parity_err(perr_a)
  );

  uart_rx_param #(
    .DBIT(DB_B), .OVERSAMPLE(OS), .SB_TICK(SB_B), .PARITY_ODD(1)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .rx(rx_b), .s_tick(s_tick),
    .rx_done_tick(done_b), .dout(dout_b), .frame_err(ferr_b), .parity_err(perr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [8:0] dat;
    logic       ferr;
    logic       perr;
    int         at;
  } rec_t;

  rec_t q_a[$];
  rec_t q_b[$];

  always @(negedge clk) begin : mon
    rec_t r;
    if (done_a) begin
      r.dat = 9'(dout_a); r.ferr = ferr_a; r.perr = perr_a; r.at = cyc;
      q_a.push_back(r);
    end
    if (done_b) begin
      r.dat = 9'(dout_b); r.ferr = ferr_b; r.perr = perr_b; r.at = cyc;
      q_b.push_back(r);
    end
  end

  int checks = 0;
  int errors = 0;
  int gap_mode = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n oversampling ticks; in gap mode ticks arrive on random clocks.
  task automatic tick(input int n);
    int c;
    c = 0;
    while (c < n) begin
      @(negedge clk);
      s_tick = (gap_mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
      if (s_tick) c++;
    end
  endtask

  task automatic set_rx(input int which, input logic v);
    if (which == 0) rx_a = v;
    else rx_b = v;
  endtask

  // One complete frame on the selected line, followed by an idle gap.
  task automatic send(input int which, input logic [8:0] data, input logic stop_bit,
                      input logic bad, output int t0);
    int   nb, sb;
    logic par;
    nb  = (which == 0) ? DB_A : DB_B;
    sb  = (which == 0) ? SB_A : SB_B;
    par = ((which == 0) ? 1'b0 : 1'b1) ^ bad;
    set_rx(which, 1'b0);
    t0 = cyc;
    tick(OS);
    for (int i = 0; i < nb; i++) begin
      set_rx(which, data[i]);
      par = par ^ data[i];
      tick(OS);
    end
    if (PB != 0) begin
      set_rx(which, par);
      tick(OS);
    end
    set_rx(which, stop_bit);
    tick(sb);
    set_rx(which, 1'b1);
    tick(OS + $urandom_range(0, 8));
  endtask

  task automatic expect_frame(input int which, input logic [8:0] data, input logic stop_bit,
                              input logic bad, input int t0);
    rec_t       r;
    int         nb, sb, cnt;
    logic [8:0] m;
    nb = (which == 0) ? DB_A : DB_B;
    sb = (which == 0) ? SB_A : SB_B;
    m  = 9'((1 << nb) - 1);
    cnt = (which == 0) ? q_a.size() : q_b.size();
    check("done_count", cnt, 1);
    if (cnt > 0) begin
      if (which == 0) r = q_a.pop_front();
      else r = q_b.pop_front();
      check("dout", r.dat, data & m);
      check("frame_err", r.ferr, !stop_bit);
      check("parity_err", r.perr, (PB != 0) ? bad : 1'b0);
      if (gap_mode == 0)
        check("latency", r.at - t0, 3 + OS / 2 + nb * OS + PB * OS + sb);
    end
    q_a.delete();
    q_b.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL timeout: bench did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int t0;
    logic [8:0] d;
    logic stp, bad;
    reset_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1; s_tick = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_done", done_a, 0);
    check("rst_dout", dout_a, 0);
    check("rst_ferr", ferr_a, 0);
    check("rst_perr", perr_a, 0);
    reset_n = 1'b1;
    tick(4);

    send(0, 9'h04D, 1'b1, 1'b0, t0);
    expect_frame(0, 9'h04D, 1'b1, 1'b0, t0);

    set_rx(0, 1'b0);
    tick(4);
    set_rx(0, 1'b1);
    tick(3 * OS);
    check("glitch_pulse", q_a.size(), 0);
    check("glitch_dout", dout_a, 8'h4D);
    check("glitch_ferr", ferr_a, 0);

    send(0, 9'h0A5, 1'b0, 1'b0, t0);
    expect_frame(0, 9'h0A5, 1'b0, 1'b0, t0);

    send(0, 9'h04D, 1'b1, 1'b0, t0);
    expect_frame(0, 9'h04D, 1'b1, 1'b0, t0);
    send(0, 9'h04D, 1'b1, 1'b1, t0);
    expect_frame(0, 9'h04D, 1'b1, 1'b1, t0);

    send(1, 9'h055, 1'b1, 1'b0, t0);
    expect_frame(1, 9'h055, 1'b1, 1'b0, t0);

    d = 9'h0F3;
    set_rx(0, 1'b0);
    tick(OS);
    for (int i = 0; i < 4; i++) begin
      set_rx(0, d[i]);
      tick(OS);
    end
    set_rx(0, d[4]);
    tick(OS / 2);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid_done", done_a, 0);
    check("rst_mid_dout", dout_a, 0);
    check("rst_mid_ferr", ferr_a, 0);
    check("rst_mid_perr", perr_a, 0);
    set_rx(0, 1'b1);
    reset_n = 1'b1;
    tick(2 * OS);
    check("rst_mid_pulse", q_a.size(), 0);
    send(0, 9'h03C, 1'b1, 1'b0, t0);
    expect_frame(0, 9'h03C, 1'b1, 1'b0, t0);

    for (int i = 0; i < 16; i++) begin
      int w;
      w        = (i % 3 == 2) ? 1 : 0;
      gap_mode = $urandom_range(0, 1);
      d        = 9'($urandom);
      stp      = ($urandom_range(0, 3) != 0);
      bad      = 1'($urandom_range(0, 1));
      send(w, d, stp, bad, t0);
      expect_frame(w, d, stp, bad, t0);
    end

    gap_mode = 0;
    tick(2 * OS);
    check("spurious_a", q_a.size(), 0);
    check("spurious_b", q_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
